// File: rtl/ula_control.sv
// ula_control: registered ALU control decoder.
// Decodes the operation class from main control (ALUOp) and, where relevant,
// the R-type or immediate function field into a 4-bit ALU control code.
// The decoded value is registered on enabled clock edges (one-cycle latency)
// and an illegal flag marks undefined R-type function codes.
module ula_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] ALUOp,
  input  logic [3:0] FuncCode_tipoR,
  input  logic [1:0] FuncCode,
  output logic [3:0] ALUCtl,
  output logic       illegal
);

  // ALU control code set
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;
  localparam logic [3:0] ALU_SLTU = 4'b1011;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_NOP  = 4'b1111;

  logic [3:0] dec_ctl;
  logic       dec_illegal;

  // Combinational decode; function fields are only examined inside the
  // ALUOp branch that uses them, so ignored fields never reach the result.
  always_comb begin
    dec_ctl     = ALU_ADD;
    dec_illegal = 1'b0;
    case (ALUOp)
      2'b00: begin
        dec_ctl     = ALU_ADD;
        dec_illegal = 1'b0;
      end
      2'b01: begin
        dec_ctl     = ALU_SUB;
        dec_illegal = 1'b0;
      end
      2'b10: begin
        dec_illegal = 1'b0;
        case (FuncCode_tipoR)
          4'b0000: dec_ctl = ALU_ADD;
          4'b0001: dec_ctl = ALU_SUB;
          4'b0010: dec_ctl = ALU_AND;
          4'b0011: dec_ctl = ALU_OR;
          4'b0100: dec_ctl = ALU_XOR;
          4'b0101: dec_ctl = ALU_NOR;
          4'b0110: dec_ctl = ALU_SLT;
          4'b0111: dec_ctl = ALU_SLL;
          4'b1000: dec_ctl = ALU_SRL;
          4'b1001: dec_ctl = ALU_SRA;
          4'b1010: dec_ctl = ALU_SLTU;
          default: begin
            // 1011..1111 are undefined: issue a NOP and flag it
            dec_ctl     = ALU_NOP;
            dec_illegal = 1'b1;
          end
        endcase
      end
      2'b11: begin
        dec_illegal = 1'b0;
        case (FuncCode)
          2'b00:   dec_ctl = ALU_ADD;  // ADDI
          2'b01:   dec_ctl = ALU_AND;  // ANDI
          2'b10:   dec_ctl = ALU_OR;   // ORI
          2'b11:   dec_ctl = ALU_SLT;  // SLTI
          default: dec_ctl = ALU_ADD;
        endcase
      end
      default: begin
        dec_ctl     = ALU_ADD;
        dec_illegal = 1'b0;
      end
    endcase
  end

  // Output register: async clear, load decoded value when enabled, else hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ALUCtl  <= 4'b0000;
      illegal <= 1'b0;
    end else if (en) begin
      ALUCtl  <= dec_ctl;
      illegal <= dec_illegal;
    end else begin
      ALUCtl  <= ALUCtl;
      illegal <= illegal;
    end
  end

endmodule

// File: tb/tb_ula_control.sv
// tb_ula_control: scoreboard bench for ula_control.
// Expected {illegal, ALUCtl} values are pushed when stimulus is driven and
// popped one enabled edge later when the registered output is sampled.
module tb_ula_control;

  logic       clk;
  logic       clk_on;
  logic       rst_n;
  logic       en;
  logic [1:0] ALUOp;
  logic [3:0] FuncCode_tipoR;
  logic [1:0] FuncCode;
  logic [3:0] ALUCtl;
  logic       illegal;

  int n_checks;
  int n_errors;

  logic [4:0] sb[$];
  logic [4:0] held;

  ula_control dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .en             (en),
    .ALUOp          (ALUOp),
    .FuncCode_tipoR (FuncCode_tipoR),
    .FuncCode       (FuncCode),
    .ALUCtl         (ALUCtl),
    .illegal        (illegal)
  );

  // Clock generator, gated so reset can be observed without any edge
  always begin
    #5;
    if (clk_on) clk = ~clk;
  end

  // Reference table for R-type function codes 0..10
  logic [3:0] rtab [0:10];
  logic [3:0] itab [0:3];

  // Reference model: {illegal, ALUCtl}
  function automatic logic [4:0] model(input logic [1:0] op, input logic [3:0] fr,
                                       input logic [1:0] fc);
    logic [4:0] r;
    r = 5'b0_0010;
    case (op)
      2'b00: r = 5'b0_0010;
      2'b01: r = 5'b0_0110;
      2'b10: begin
        if (fr <= 4'd10) r = {1'b0, rtab[fr]};
        else             r = 5'b1_1111;
      end
      2'b11: r = {1'b0, itab[fc]};
      default: r = 5'b0_0010;
    endcase
    return r;
  endfunction

  task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got illegal/ALUCtl=%b expected %b", tag, obs, exp);
    end
  endtask

  // Drive one set of inputs at negedge, then compare one edge later
  task automatic apply(input string tag, input logic [1:0] op, input logic [3:0] fr,
                       input logic [1:0] fc, input logic e);
    logic [4:0] exp;
    @(negedge clk);
    ALUOp          = op;
    FuncCode_tipoR = fr;
    FuncCode       = fc;
    en             = e;
    if (e) held = model(op, fr, fc);
    sb.push_back(held);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      exp = sb.pop_front();
      check(tag, {illegal, ALUCtl}, exp);
    end
    // Disturb inputs between edges; only the next sampled value may count
    #1;
    ALUOp          = 2'($urandom);
    FuncCode_tipoR = 4'($urandom);
    FuncCode       = 2'($urandom);
  endtask

  // Watchdog so the run always ends
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rtab = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0011, 4'b1100,
             4'b0111, 4'b1000, 4'b1001, 4'b1010, 4'b1011};
    itab = '{4'b0010, 4'b0000, 4'b0001, 4'b0111};
    n_checks = 0;
    n_errors = 0;
    held     = 5'b0;
    clk      = 1'b0;
    clk_on   = 1'b0;
    rst_n    = 1'b1;
    en       = 1'b1;
    ALUOp          = 2'b10;
    FuncCode_tipoR = 4'b1111;
    FuncCode       = 2'b11;

    // Reset with arbitrary inputs and no clock edge
    #3 rst_n = 1'b0;
    #2 check("rst_noclk", {illegal, ALUCtl}, 5'b0);
    clk_on = 1'b1;
    repeat (2) @(posedge clk);
    #1 check("rst_held", {illegal, ALUCtl}, 5'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Load/store then branch on consecutive edges
    apply("lw",  2'b00, 4'b1111, 2'b11, 1'b1);
    apply("br",  2'b01, 4'b1101, 2'b10, 1'b1);
    // R-type SRL and an illegal code
    apply("srl", 2'b10, 4'b1000, 2'b00, 1'b1);
    apply("ill", 2'b10, 4'b1111, 2'b00, 1'b1);
    apply("nor", 2'b10, 4'b0101, 2'b00, 1'b1);
    // Immediate class
    for (int i = 0; i < 4; i++) apply("imm", 2'b11, 4'b1011, 2'(i), 1'b1);

    // Hold with en=0 while inputs change
    apply("ld_sub", 2'b01, 4'b0000, 2'b00, 1'b1);
    apply("hold1",  2'b10, 4'b0101, 2'b00, 1'b0);
    apply("hold2",  2'b10, 4'b1110, 2'b01, 1'b0);
    apply("resume", 2'b10, 4'b0101, 2'b00, 1'b1);

    // Exhaustive sweep
    for (int o = 0; o < 4; o++)
      for (int r = 0; r < 16; r++)
        for (int f = 0; f < 4; f++)
          apply("sweep", 2'(o), 4'(r), 2'(f), 1'b1);

    // Reset mid-operation overrides en and inputs immediately
    apply("pre_rst", 2'b10, 4'b1100, 2'b00, 1'b1);
    @(negedge clk);
    en    = 1'b1;
    ALUOp = 2'b10;
    FuncCode_tipoR = 4'b1101;
    #2 rst_n = 1'b0;
    #1 check("rst_mid", {illegal, ALUCtl}, 5'b0);
    held = 5'b0;
    @(posedge clk);
    #1 check("rst_mid_edge", {illegal, ALUCtl}, 5'b0);
    @(negedge clk);
    rst_n = 1'b1;
    apply("post_rst", 2'b10, 4'b1010, 2'b00, 1'b1);
    apply("post_rst_hold", 2'b00, 4'b0000, 2'b00, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
